nn_bg_receiver: RTL
===================

// Module: nn_bg_receiver
// PURPOSE
//  Receive end of the burst-gated node link. Decodes the burst train driven by a
//  node's burst transmitter (a_out) back into a stochastic bitstream for the
//  downstream layer's a[] input. Validates burst length and refractory spacing,
//  keeps a leaky event-rate estimate, and regenerates OUT by comparing that
//  estimate against a shared random number.
// PARAMETERS
//  PULSE_DURATION      80  nominal burst length, in cycles
//  TOLERANCE           8   accepted burst length = PULSE_DURATION +/- TOLERANCE
//  REFRACTORY_DURATION 10  minimum low cycles required after a valid burst
//  COUNTER_SIZE        8   width of the burst-length counter (saturating)
//  RATE_SIZE           8   width of the rate estimate and of R
//  RATE_STEP           32  RATE increment per valid burst
//  DECAY_PERIOD        64  cycles per 1-LSB RATE decrement
// PORTS
//  CLK        in   1             clock, rising edge
//  INIT       in   1             reset, asynchronous, active-low
//  IN         in   1             burst line from the transmitting node
//  R          in   RATE_SIZE     random number, fresh each cycle
//  OUT        out  1             regenerated stochastic stream, registered
//  EVENT      out  1             1-cycle pulse: valid burst received
//  ERR        out  1             1-cycle pulse: malformed burst or spacing
//  BURST_LEN  out  COUNTER_SIZE  length of the last valid burst, held
//  RATE       out  RATE_SIZE     current rate estimate
// BEHAVIOUR
//  Reset (INIT=0, async): state=IDLE, all counters 0, all outputs 0.
//  IN is sampled on every rising edge. cnt counts consecutive sampled 1s.
//  FSM states:
//   IDLE:  IN=1 -> BURST, cnt=1.
//   BURST: IN=1 -> cnt++. If cnt reaches 2^COUNTER_SIZE-1: ERR, then STUCK.
//          IN=0, length in window -> EVENT, BURST_LEN<=cnt, then REFR, rcnt=1.
//          IN=0, length outside window -> ERR, then IDLE. BURST_LEN held.
//   REFR:  IN=0 -> rcnt++. When rcnt==REFRACTORY_DURATION -> IDLE.
//          IN=1 before that -> ERR, then BURST with cnt=1. The new burst is
//          still measured and may produce EVENT.
//   STUCK: stay until IN=0 -> IDLE. No further ERR while stuck.
//  Latency: EVENT, ERR and BURST_LEN update in the cycle after the deciding
//   IN sample. EVENT and ERR are never high in the same cycle.
//  RATE update:
//   - decay counter wraps every DECAY_PERIOD cycles; at the wrap, RATE-=1,
//     saturating at 0.
//   - on EVENT, RATE+=RATE_STEP, saturating at 2^RATE_SIZE-1.
//   - EVENT and decay in the same cycle: RATE+RATE_STEP-1, then saturate.
//  OUT <= (R < RATE). RATE=0 gives a constant 0 stream. RATE=max gives 1
//   except when R equals max.
//  Counters never wrap; every counter saturates.
//  Reset mid-burst discards the partial burst.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE, BURST, REFR, STUCK) and the
//   default PULSE, REFRACTORY and RATE constants shared with the transmitter.
//  One sub-module: nn_rate_leaky, which holds RATE, the decay counter and the
//   saturating add/subtract. The top level holds the FSM, the counters and
//   the comparator.
// TESTING
//  1 After reset: 80 ones then 20 zeros -> one EVENT, BURST_LEN=80, RATE=32,
//    ERR never asserted.
//  2 Burst of 60 ones -> ERR one cycle after the falling sample, no EVENT,
//    BURST_LEN and RATE unchanged.
//  3 80 ones, 5 zeros, 80 ones -> EVENT, then ERR on the early rising sample,
//    then a second EVENT. RATE=64 absent decay.
//  4 IN held high for 300 cycles -> exactly one ERR at cnt=255, no EVENT,
//    FSM returns to IDLE only after IN=0.
//  5 Ten valid bursts back-to-back -> RATE saturates at 255. Then 255*64 idle
//    cycles -> RATE=0. Sweep R over 0..255 at RATE=128 -> OUT=1 for exactly 128
//    of the values.
//  6 INIT pulled low mid-burst (cnt=40) -> outputs 0 immediately, no EVENT.
//    After release, an 80-cycle burst -> EVENT with BURST_LEN=80.

Source files
------------

// File: rtl/nn_bg_receiver_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nn_bg_receiver_pkg
//  Purpose  : Shared definitions for the burst-gated node link receiver:
//             FSM state encoding and the default burst / refractory / rate
//             constants that the transmitter side uses as well.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package nn_bg_receiver_pkg;

  // Link timing shared with the burst transmitter
  localparam int DEF_PULSE_DURATION      = 80;
  localparam int DEF_TOLERANCE           = 8;
  localparam int DEF_REFRACTORY_DURATION = 10;

  // Receiver datapath widths and rate-estimate dynamics
  localparam int DEF_COUNTER_SIZE        = 8;
  localparam int DEF_RATE_SIZE           = 8;
  localparam int DEF_RATE_STEP           = 32;
  localparam int DEF_DECAY_PERIOD        = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_REFR  = 2'd2,
    ST_STUCK = 2'd3
  } state_t;

endpackage : nn_bg_receiver_pkg
`default_nettype wire

// File: rtl/nn_bg_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module   : nn_bg_receiver_if
//  Purpose  : Signal bundle between the burst line / random source and the
//             receiver. The slave modport is the receiver's view, the master
//             modport is the view of whatever drives IN and R.
//  Signals  : IN        burst line from the transmitting node
//             R         random number, fresh each cycle
//             OUT       regenerated stochastic stream
//             EVENT     1-cycle pulse, valid burst received
//             ERR       1-cycle pulse, malformed burst or spacing
//             BURST_LEN length of the last valid burst
//             RATE      current rate estimate
//  Revision : 1.0  initial release
// ============================================================================
interface nn_bg_receiver_if
  import nn_bg_receiver_pkg::*;
#(
  parameter int COUNTER_SIZE = DEF_COUNTER_SIZE,
  parameter int RATE_SIZE    = DEF_RATE_SIZE
);
  logic                    IN;
  logic [RATE_SIZE-1:0]    R;
  logic                    OUT;
  logic                    EVENT;
  logic                    ERR;
  logic [COUNTER_SIZE-1:0] BURST_LEN;
  logic [RATE_SIZE-1:0]    RATE;

  modport slave (
    input  IN, R,
    output OUT, EVENT, ERR, BURST_LEN, RATE
  );

  modport master (
    output IN, R,
    input  OUT, EVENT, ERR, BURST_LEN, RATE
  );
endinterface : nn_bg_receiver_if
`default_nettype wire

// File: rtl/nn_bg_receiver_rate_leaky.sv
`default_nettype none
// ============================================================================
//  Module   : nn_rate_leaky
//  Purpose  : Leaky event-rate estimate. Adds RATE_STEP per event, removes one
//             LSB every DECAY_PERIOD cycles, saturating at both ends.
//  Ports    : clk    clock, rising edge
//             rst_n  asynchronous active-low reset
//             ev     one-cycle event pulse
//             rate   current rate estimate (registered)
//  Revision : 1.0  initial release
// ============================================================================
module nn_rate_leaky
  import nn_bg_receiver_pkg::*;
#(
  parameter int RATE_SIZE    = DEF_RATE_SIZE,
  parameter int RATE_STEP    = DEF_RATE_STEP,
  parameter int DECAY_PERIOD = DEF_DECAY_PERIOD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ev,
  output logic [RATE_SIZE-1:0] rate
);

  localparam int DW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  // Two guard bits: one for the overflow of rate + step, one spare
  localparam int SW = RATE_SIZE + 2;

  localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_PERIOD - 1);
  localparam logic [SW-1:0] RATE_MAX   = {2'b00, {RATE_SIZE{1'b1}}};
  localparam logic [SW-1:0] STEP_W     = SW'(RATE_STEP);
  localparam logic [SW-1:0] ONE_W      = SW'(1);
  localparam logic [DW-1:0] ONE_D      = DW'(1);

  logic [DW-1:0] decay_cnt;
  logic          decay_tick;
  logic [SW-1:0] rate_next;

  assign decay_tick = (decay_cnt == DECAY_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decay_cnt <= '0;
    end else if (decay_tick) begin
      decay_cnt <= '0;
    end else begin
      decay_cnt <= decay_cnt + ONE_D;
    end
  end

  // Increment first, then decrement, then clamp: an event coinciding with a
  // decay tick yields rate + step - 1 before saturation.
  always_comb begin
    rate_next = {2'b00, rate};
    if (ev) begin
      rate_next = rate_next + STEP_W;
    end
    if (decay_tick && (rate_next != '0)) begin
      rate_next = rate_next - ONE_W;
    end
    if (rate_next > RATE_MAX) begin
      rate_next = RATE_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate <= '0;
    end else begin
      rate <= rate_next[RATE_SIZE-1:0];
    end
  end

endmodule : nn_rate_leaky
`default_nettype wire

// File: rtl/nn_bg_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : nn_bg_receiver
//  Purpose  : Receive end of the burst-gated node link. Measures incoming
//             bursts, validates length and refractory spacing, feeds a leaky
//             rate estimate and regenerates a stochastic stream OUT = R < RATE.
//  Ports    : CLK   clock, rising edge
//             INIT  asynchronous active-low reset
//             bus   slave side of nn_bg_receiver_if (IN, R in; OUT, EVENT,
//                   ERR, BURST_LEN, RATE out)
//  Revision : 1.0  initial release
// ============================================================================
module nn_bg_receiver
  import nn_bg_receiver_pkg::*;
#(
  parameter int PULSE_DURATION      = DEF_PULSE_DURATION,
  parameter int TOLERANCE           = DEF_TOLERANCE,
  parameter int REFRACTORY_DURATION = DEF_REFRACTORY_DURATION,
  parameter int COUNTER_SIZE        = DEF_COUNTER_SIZE,
  parameter int RATE_SIZE           = DEF_RATE_SIZE,
  parameter int RATE_STEP           = DEF_RATE_STEP,
  parameter int DECAY_PERIOD        = DEF_DECAY_PERIOD
) (
  input  logic             CLK,
  input  logic             INIT,
  nn_bg_receiver_if.slave  bus
);

  localparam int RW = $clog2(REFRACTORY_DURATION + 1);

  localparam logic [COUNTER_SIZE-1:0] CNT_MAX  = '1;
  localparam logic [COUNTER_SIZE-1:0] CNT_ONE  = COUNTER_SIZE'(1);
  localparam logic [COUNTER_SIZE-1:0] LEN_MIN  = COUNTER_SIZE'(PULSE_DURATION - TOLERANCE);
  localparam logic [COUNTER_SIZE-1:0] LEN_MAX  = COUNTER_SIZE'(PULSE_DURATION + TOLERANCE);
  localparam logic [RW-1:0]           RCNT_ONE = RW'(1);
  localparam logic [RW-1:0]           RCNT_END = RW'(REFRACTORY_DURATION - 1);

  state_t                  state;
  logic [COUNTER_SIZE-1:0] cnt;
  logic [RW-1:0]           rcnt;
  logic                    event_r;
  logic                    err_r;
  logic [COUNTER_SIZE-1:0] burst_len_r;
  logic                    out_r;
  logic [RATE_SIZE-1:0]    rate;
  logic                    len_ok;

  assign len_ok = (cnt >= LEN_MIN) && (cnt <= LEN_MAX);

  always_ff @(posedge CLK or negedge INIT) begin
    if (!INIT) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rcnt        <= '0;
      event_r     <= 1'b0;
      err_r       <= 1'b0;
      burst_len_r <= '0;
    end else begin
      event_r <= 1'b0;
      err_r   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.IN) begin
            state <= ST_BURST;
            cnt   <= CNT_ONE;
          end
        end

        ST_BURST: begin
          if (bus.IN) begin
            // Flag once when the counter hits its ceiling; the line is then
            // treated as stuck until it drops.
            if (cnt == CNT_MAX - CNT_ONE) begin
              cnt   <= CNT_MAX;
              err_r <= 1'b1;
              state <= ST_STUCK;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end else if (len_ok) begin
            event_r     <= 1'b1;
            burst_len_r <= cnt;
            cnt         <= '0;
            rcnt        <= RCNT_ONE;
            state       <= ST_REFR;
          end else begin
            err_r <= 1'b1;
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end

        ST_REFR: begin
          if (bus.IN) begin
            // Spacing violation, but the new burst is measured normally.
            err_r <= 1'b1;
            rcnt  <= '0;
            cnt   <= CNT_ONE;
            state <= ST_BURST;
          end else if (rcnt >= RCNT_END) begin
            rcnt  <= '0;
            state <= ST_IDLE;
          end else begin
            rcnt <= rcnt + RCNT_ONE;
          end
        end

        ST_STUCK: begin
          if (!bus.IN) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end

        default: begin
          cnt   <= '0;
          rcnt  <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  nn_rate_leaky #(
    .RATE_SIZE    (RATE_SIZE),
    .RATE_STEP    (RATE_STEP),
    .DECAY_PERIOD (DECAY_PERIOD)
  ) u_rate (
    .clk   (CLK),
    .rst_n (INIT),
    .ev    (event_r),
    .rate  (rate)
  );

  always_ff @(posedge CLK or negedge INIT) begin
    if (!INIT) begin
      out_r <= 1'b0;
    end else begin
      out_r <= (bus.R < rate);
    end
  end

  assign bus.OUT       = out_r;
  assign bus.EVENT     = event_r;
  assign bus.ERR       = err_r;
  assign bus.BURST_LEN = burst_len_r;
  assign bus.RATE      = rate;

endmodule : nn_bg_receiver
`default_nettype wire
